sudoku_board_checker: RTL and testbench
=======================================

# sudoku_board_checker

Compares the player's current board against the solution delivered by the map selector and reports whether the puzzle is solved. It sits between the game controller and the board-state registers, consuming the selected map and visibility words. It is launched by a single-cycle start and answers with a one-cycle done pulse plus latched result counters. Cells are scanned one per clock, so the block stays small regardless of board size.

## Interface
- No parameters; sizes come from the shared package (81 cells, 4-bit values, 2-bit visibility).
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  request a check; honoured only in IDLE
- solution_map  in  324  solution, cell i at [4i+3:4i], values 1..9
- visibility  in  162  cell i at [2i+1:2i]; 2'b00 = player cell, anything else = given cell
- player_board  in  324  player entries, cell i at [4i+3:4i], 0 = empty
- busy  out  1  high while scanning
- done  out  1  one-cycle pulse when results become valid
- solved  out  1  1 when the last check found zero errors and zero empties
- error_count  out  7  player cells holding a wrong value (nonzero, mismatching)
- empty_count  out  7  player cells holding 0
- first_error_valid  out  1  at least one error was found
- first_error_index  out  7  lowest cell index with an error (0..80)

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: on start=1, snapshot solution_map, visibility and player_board into internal registers. Clear counters, first_error_valid and solved. Set index=0 and go to SCAN. Inputs may change freely after the start cycle.
- SCAN: examine cell[index] from the snapshot each cycle:
  - given cell: skipped, no counter change;
  - player value 0: empty_count+1;
  - player value 10..15, or 1..9 not equal to the solution: error_count+1; if first_error_valid=0, latch index and set first_error_valid;
  - equal to the solution: no change.
- SCAN exit: after index 80, go to DONE. Counters saturate at 81 by construction; no wrap handling is needed.
- DONE: for one cycle, done=1 and solved=(error_count==0 && empty_count==0); then return to IDLE.
- Results hold until the next accepted start.
- start while busy or in DONE is ignored; it is not queued.
- reset at any time, including mid-scan: state goes to IDLE and all outputs and counters go to 0. A partial scan is discarded.

## Timing
- Reset values: busy=0, done=0, solved=0, error_count=0, empty_count=0, first_error_valid=0, first_error_index=0.
- start sampled high at edge T: busy=1 from T+1. Cell k is evaluated in cycle T+1+k.
- done=1 in cycle T+82 with busy=0. Outputs are valid from T+82 until the next start. Minimum start-to-start interval is 83 cycles.
- All outputs are registered; there is no combinational path from the inputs.

## Configuration
- SUDOKU_CHECK_EARLY_EXIT_EN defined: the first error ends SCAN.
  - Error at cell k gives done at T+k+2.
  - Counters cover cells 0..k only, and error_count=1.
  - solved=0.
- Not defined: a full 81-cell scan always runs and the counts are exact.

## Structure
- Shared package sudoku_pkg holds:
  - CELLS=81, CELL_W=4, VIS_W=2, MAP_W=324, VIS_W_TOTAL=162;
  - the checker state enum;
  - a cell-index type of 7 bits.
- One sub-module: sudoku_cell_compare. It is combinational and takes expected value, player value and visibility field. It returns the class: skip, empty, error or ok.
- The top level holds the FSM, the snapshot registers, the index counter and the result registers.

## Test plan
- Player board equals the solution at every player cell, 40 given cells -> done at T+82, solved=1, error_count=0, empty_count=0, first_error_valid=0.
- Cells 5 and 70 are player cells left at 0 -> empty_count=2, error_count=0, solved=0.
- Cell 12 holds 3 where the solution is 7, cell 40 holds 15 -> error_count=2, first_error_index=12, first_error_valid=1. With SUDOKU_CHECK_EARLY_EXIT_EN, done at T+14 and error_count=1.
- A given cell whose player value differs from the solution -> ignored, solved=1.
- start re-asserted at T+30 during the scan, and player_board changed at T+2 -> no restart, and results reflect the board captured at T.
- reset asserted at T+40 -> all outputs 0 the next cycle, no done pulse. A fresh start then completes normally after 82 cycles.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared sizes and types for the sudoku board checker.
// The optional SUDOKU_CHECK_EARLY_EXIT_EN build is handled in the top level.
package sudoku_pkg;

  localparam int CELLS       = 81;
  localparam int CELL_W      = 4;
  localparam int VIS_W       = 2;
  localparam int MAP_W       = CELLS * CELL_W;
  localparam int VIS_W_TOTAL = CELLS * VIS_W;

  typedef logic [6:0] cell_idx_t;

  localparam cell_idx_t LAST_IDX = 7'(CELLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } check_state_t;

  typedef enum logic [1:0] {
    CELL_SKIP,
    CELL_EMPTY,
    CELL_ERROR,
    CELL_OK
  } cell_class_t;

endpackage

// File: rtl/sudoku_board_checker_compare.sv
// Combinational classification of one cell: skip (given), empty, error or ok.
module sudoku_cell_compare
  import sudoku_pkg::*;
(
  input  logic [CELL_W-1:0] expected,
  input  logic [CELL_W-1:0] player,
  input  logic [VIS_W-1:0]  vis,
  output cell_class_t       cell_class
);

  // Out-of-range entries (10..15) count as errors even though they can never match.
  always_comb begin
    cell_class = CELL_OK;
    if (vis != '0) begin
      cell_class = CELL_SKIP;
    end else if (player == '0) begin
      cell_class = CELL_EMPTY;
    end else if ((player > 4'd9) || (player != expected)) begin
      cell_class = CELL_ERROR;
    end
  end

endmodule

// File: rtl/sudoku_board_checker.sv
// Scans a snapshot of the board one cell per clock and latches error/empty results.
// Build option: SUDOKU_CHECK_EARLY_EXIT_EN stops the scan at the first error.
module sudoku_board_checker
  import sudoku_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [MAP_W-1:0]       solution_map,
  input  logic [VIS_W_TOTAL-1:0] visibility,
  input  logic [MAP_W-1:0]       player_board,
  output logic                   busy,
  output logic                   done,
  output logic                   solved,
  output logic [6:0]             error_count,
  output logic [6:0]             empty_count,
  output logic                   first_error_valid,
  output logic [6:0]             first_error_index
);

  check_state_t state_q, state_d;

  logic [MAP_W-1:0]       sol_q;
  logic [VIS_W_TOTAL-1:0] vis_q;
  logic [MAP_W-1:0]       ply_q;
  cell_idx_t              index_q;

  logic [6:0] err_d, emp_d, fei_d;
  logic       fev_d, solved_d;
  logic       accept;

  cell_class_t cls;

  assign accept = (state_q == IDLE) && start;

  // The snapshots shift down each scan cycle, so the current cell always sits in the low bits.
  sudoku_cell_compare u_compare (
    .expected   (sol_q[CELL_W-1:0]),
    .player     (ply_q[CELL_W-1:0]),
    .vis        (vis_q[VIS_W-1:0]),
    .cell_class (cls)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = error_count;
    emp_d    = empty_count;
    fev_d    = first_error_valid;
    fei_d    = first_error_index;
    solved_d = solved;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN;
          err_d    = '0;
          emp_d    = '0;
          fev_d    = 1'b0;
          fei_d    = '0;
          solved_d = 1'b0;
        end
      end
      SCAN: begin
        case (cls)
          CELL_EMPTY: emp_d = empty_count + 7'd1;
          CELL_ERROR: begin
            err_d = error_count + 7'd1;
            if (!first_error_valid) begin
              fev_d = 1'b1;
              fei_d = index_q;
            end
          end
          default: ;
        endcase
        if (index_q == LAST_IDX) state_d = DONE;
`ifdef SUDOKU_CHECK_EARLY_EXIT_EN
        if (cls == CELL_ERROR) state_d = DONE;
`endif
        // Solved is resolved on the exit edge so it is valid together with done.
        if (state_d == DONE) solved_d = (err_d == '0) && (emp_d == '0);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      solved            <= 1'b0;
      error_count       <= '0;
      empty_count       <= '0;
      first_error_valid <= 1'b0;
      first_error_index <= '0;
    end else begin
      state_q           <= state_d;
      busy              <= (state_d == SCAN);
      done              <= (state_d == DONE);
      solved            <= solved_d;
      error_count       <= err_d;
      empty_count       <= emp_d;
      first_error_valid <= fev_d;
      first_error_index <= fei_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sol_q   <= '0;
      vis_q   <= '0;
      ply_q   <= '0;
      index_q <= '0;
    end else if (accept) begin
      sol_q   <= solution_map;
      vis_q   <= visibility;
      ply_q   <= player_board;
      index_q <= '0;
    end else if (state_q == SCAN) begin
      sol_q   <= {{CELL_W{1'b0}}, sol_q[MAP_W-1:CELL_W]};
      vis_q   <= {{VIS_W{1'b0}}, vis_q[VIS_W_TOTAL-1:VIS_W]};
      ply_q   <= {{CELL_W{1'b0}}, ply_q[MAP_W-1:CELL_W]};
      index_q <= index_q + 7'd1;
    end
  end

endmodule

// File: tb/tb_sudoku_board_checker.sv
// Directed, table-driven bench for sudoku_board_checker plus restart and reset sequences.
module tb_sudoku_board_checker;
  import sudoku_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [MAP_W-1:0]       solution_map;
  logic [VIS_W_TOTAL-1:0] visibility;
  logic [MAP_W-1:0]       player_board;
  logic                   busy, done, solved, first_error_valid;
  logic [6:0]             error_count, empty_count, first_error_index;

  int checks = 0;
  int errors = 0;

  sudoku_board_checker dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .solution_map      (solution_map),
    .visibility        (visibility),
    .player_board      (player_board),
    .busy              (busy),
    .done              (done),
    .solved            (solved),
    .error_count       (error_count),
    .empty_count       (empty_count),
    .first_error_valid (first_error_valid),
    .first_error_index (first_error_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    name;
    logic     all_empty;
    int       idx_a;
    logic [3:0] val_a;
    int       idx_b;
    logic [3:0] val_b;
    logic     exp_solved;
    int       exp_err;
    int       exp_emp;
    logic     exp_fev;
    int       exp_fei;
    int       exp_lat;
  } vec_t;

  vec_t vecs[7];

  // Valid sudoku: row r is the base row rotated by 3*r + r/3.
  function automatic logic [3:0] sol_cell(input int i);
    int r, c;
    r = i / 9;
    c = i % 9;
    return 4'(((r * 3 + r / 3 + c) % 9) + 1);
  endfunction

  // 40 given cells: 19 and 20..59 except 40.
  function automatic logic is_given(input int i);
    return (i == 19) || (i >= 20 && i < 60 && i != 40);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic build_boards(input vec_t v);
    for (int i = 0; i < CELLS; i++) begin
      solution_map[4*i +: 4] = sol_cell(i);
      visibility[2*i +: 2]   = is_given(i) ? 2'((i % 3) + 1) : 2'b00;
      player_board[4*i +: 4] = (v.all_empty && !is_given(i)) ? 4'd0 : sol_cell(i);
    end
    if (v.idx_a >= 0) player_board[4*v.idx_a +: 4] = v.val_a;
    if (v.idx_b >= 0) player_board[4*v.idx_b +: 4] = v.val_b;
  endtask

  // Pulses start, scrambles the inputs after capture, returns the cycle in which done rose.
  task automatic applyStimulus(input vec_t v, output int lat);
    build_boards(v);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    player_board = '1;
    solution_map = '0;
    visibility   = '0;
    checkOutput({v.name, "_busy_c1"}, int'(busy), 1);
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vector(input vec_t v);
    int lat;
    applyStimulus(v, lat);
    checkOutput({v.name, "_latency"}, lat, v.exp_lat);
    checkOutput({v.name, "_busy_at_done"}, int'(busy), 0);
    checkOutput({v.name, "_solved"}, int'(solved), int'(v.exp_solved));
    checkOutput({v.name, "_error_count"}, int'(error_count), v.exp_err);
    checkOutput({v.name, "_empty_count"}, int'(empty_count), v.exp_emp);
    checkOutput({v.name, "_first_error_valid"}, int'(first_error_valid), int'(v.exp_fev));
    checkOutput({v.name, "_first_error_index"}, int'(first_error_index), v.exp_fei);
    @(posedge clk);
    #1;
    checkOutput({v.name, "_done_pulse_end"}, int'(done), 0);
    checkOutput({v.name, "_error_count_hold"}, int'(error_count), v.exp_err);
  endtask

  initial begin
    int   lat;
    int   cyc;
    int   done_seen;
    vec_t seq;

    vecs[0] = '{"all_correct",   1'b0, -1, 4'd0, -1, 4'd0, 1'b1, 0, 0, 1'b0, 0, 82};
    vecs[1] = '{"empties_5_70",  1'b0, 5, 4'd0, 70, 4'd0, 1'b0, 0, 2, 1'b0, 0, 82};
`ifdef SUDOKU_CHECK_EARLY_EXIT_EN
    vecs[2] = '{"errors_12_40",  1'b0, 12, 4'd3, 40, 4'd15, 1'b0, 1, 0, 1'b1, 12, 14};
    vecs[5] = '{"empty0_err2",   1'b0, 0, 4'd0, 2, 4'd10, 1'b0, 1, 1, 1'b1, 2, 4};
`else
    vecs[2] = '{"errors_12_40",  1'b0, 12, 4'd3, 40, 4'd15, 1'b0, 2, 0, 1'b1, 12, 82};
    vecs[5] = '{"empty0_err2",   1'b0, 0, 4'd0, 2, 4'd10, 1'b0, 1, 1, 1'b1, 2, 82};
`endif
    vecs[3] = '{"given_diff",    1'b0, 30, 4'd0, 31, 4'd15, 1'b1, 0, 0, 1'b0, 0, 82};
    vecs[4] = '{"last_cell_err", 1'b0, 80, 4'd9, -1, 4'd0, 1'b0, 1, 0, 1'b1, 80, 82};
    vecs[6] = '{"all_empty",     1'b1, -1, 4'd0, -1, 4'd0, 1'b0, 0, 41, 1'b0, 0, 82};

    reset        = 1'b1;
    start        = 1'b0;
    solution_map = '0;
    visibility   = '0;
    player_board = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_solved", int'(solved), 0);
    checkOutput("reset_error_count", int'(error_count), 0);
    checkOutput("reset_empty_count", int'(empty_count), 0);
    checkOutput("reset_first_error_valid", int'(first_error_valid), 0);
    checkOutput("reset_first_error_index", int'(first_error_index), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vector(vecs[i]);

    // Start re-asserted mid-scan and board edited after capture: neither may affect the run.
    seq = '{"restart", 1'b0, 5, 4'd0, 60, 4'd1, 1'b0, 1, 1, 1'b1, 60, 82};
    build_boards(seq);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 200) begin
      if (cyc == 2) begin
        player_board[4*5 +: 4]  = sol_cell(5);
        player_board[4*60 +: 4] = sol_cell(60);
      end
      start = (cyc == 30);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
`ifdef SUDOKU_CHECK_EARLY_EXIT_EN
    checkOutput("restart_latency", cyc, 62);
`else
    checkOutput("restart_latency", cyc, 82);
`endif
    checkOutput("restart_error_count", int'(error_count), 1);
    checkOutput("restart_empty_count", int'(empty_count), 1);
    checkOutput("restart_first_error_index", int'(first_error_index), 60);
    checkOutput("restart_solved", int'(solved), 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("start_in_done_ignored", int'(busy), 0);
    @(posedge clk);
    #1;
    checkOutput("start_in_done_not_queued", int'(busy), 0);
    checkOutput("results_hold_idle", int'(error_count), 1);

    // Reset mid-scan discards the partial result and must not produce a done pulse.
    seq = '{"reset_mid", 1'b0, 0, 4'd0, 5, 4'd0, 1'b0, 0, 2, 1'b0, 0, 82};
    build_boards(seq);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("pre_reset_empty_count", int'(empty_count), 2);
    reset = 1'b1;
    #1;
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_empty_count", int'(empty_count), 0);
    @(posedge clk);
    #1;
    checkOutput("midreset_done", int'(done), 0);
    checkOutput("midreset_solved", int'(solved), 0);
    @(negedge clk);
    reset     = 1'b0;
    done_seen = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    checkOutput("no_activity_after_reset", done_seen, 0);
    applyStimulus(vecs[0], lat);
    checkOutput("post_reset_latency", lat, 82);
    checkOutput("post_reset_solved", int'(solved), 1);
    checkOutput("post_reset_empty_count", int'(empty_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
